// File: rtl/cordic_fix2float.sv
// Converts a signed Q2.30 CORDIC result to IEEE-754 single, normalising one bit per cycle.
// Define CORDIC_FIX2FLOAT_ROUND_EN for round-to-nearest-even; otherwise the low 8 bits are truncated.
module cordic_fix2float #(
    parameter int unsigned EXP_TOP = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done
);

    localparam logic [7:0] EXP_INIT = 8'(EXP_TOP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        sign, sign_n;
    logic        zero, zero_n;
    logic [31:0] mag, mag_n;
    logic [7:0]  exp, exp_n;
    logic [31:0] result_n;
    logic        done_n;
    logic [30:0] packed_bits;

`ifdef CORDIC_FIX2FLOAT_ROUND_EN
    logic round_inc;
    assign round_inc = mag[7] & ((|mag[6:0]) | mag[8]);
    // A mantissa carry ripples straight into the exponent field.
    assign packed_bits = {exp, mag[30:8]} + {30'd0, round_inc};
`else
    logic unused_low_bits;
    assign unused_low_bits = ^mag[7:0];
    assign packed_bits = {exp, mag[30:8]};
`endif

    always_comb begin
        state_n  = state;
        sign_n   = sign;
        zero_n   = zero;
        mag_n    = mag;
        exp_n    = exp;
        result_n = result;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = NORM;
                    sign_n  = dataa[31];
                    mag_n   = dataa[31] ? (~dataa + 32'd1) : dataa;
                    exp_n   = EXP_INIT;
                    zero_n  = 1'b0;
                end
            end
            NORM: begin
                if (mag == '0) begin
                    zero_n  = 1'b1;
                    state_n = PACK;
                end else if (mag[31]) begin
                    state_n = PACK;
                end else begin
                    mag_n = {mag[30:0], 1'b0};
                    exp_n = exp - 8'd1;
                end
            end
            PACK: begin
                result_n = zero ? '0 : {sign, packed_bits};
                done_n   = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sign   <= 1'b0;
            zero   <= 1'b0;
            mag    <= '0;
            exp    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else if (clk_en) begin
            state  <= state_n;
            sign   <= sign_n;
            zero   <= zero_n;
            mag    <= mag_n;
            exp    <= exp_n;
            result <= result_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_cordic_fix2float.sv
// Directed self-checking bench for cordic_fix2float (honours CORDIC_FIX2FLOAT_ROUND_EN).
module tb_cordic_fix2float;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] result;
    logic        done;

    int errors = 0;
    int checks = 0;

`ifdef CORDIC_FIX2FLOAT_ROUND_EN
    localparam logic [31:0] R_7FFF = 32'h40000000;
    localparam logic [31:0] R_26DD = 32'h3F1B74EE;
`else
    localparam logic [31:0] R_7FFF = 32'h3FFFFFFF;
    localparam logic [31:0] R_26DD = 32'h3F1B74ED;
`endif

    cordic_fix2float #(.EXP_TOP(128)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Called at posedge+1; start is sampled on the next edge. Cycle count n is
    // the number of edges from the sampling edge to the one raising done, plus 1.
    task automatic run_conv(input string tag, input logic [31:0] a, input logic [31:0] want,
                            input int want_lat, input bit poke, input int stall_at);
        int n;
        start = 1'b1;
        dataa = a;
        @(posedge clk); #1;
        start = 1'b0;
        dataa = 32'h12345678;
        n = 1;
        check32({tag, "_done_low"}, {31'd0, done}, 32'd0);
        while (done !== 1'b1 && n < 80) begin
            if (stall_at != 0 && n == stall_at) clk_en = 1'b0;
            if (stall_at != 0 && n == stall_at + 5) clk_en = 1'b1;
            if (poke && n == 1) start = 1'b1;
            if (poke && n == 2) start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check32({tag, "_latency"}, n, want_lat);
        check32({tag, "_result"}, result, want);
    endtask

    initial begin
        int seen;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check32("reset_result", result, 32'h0);
        check32("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_conv("one_poke", 32'h40000000, 32'h3F800000, 4, 1'b1, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check32("poke_ignored", seen, 0);

        run_conv("neg_two", 32'h80000000, 32'hC0000000, 3, 1'b0, 0);
        run_conv("zero", 32'h00000000, 32'h00000000, 3, 1'b0, 0);
        run_conv("neg_one", 32'hC0000000, 32'hBF800000, 4, 1'b0, 0);
        run_conv("max_pos", 32'h7FFFFFFF, R_7FFF, 4, 1'b0, 0);
        run_conv("min_neg", 32'hFFFFFFFF, 32'hB0800000, 34, 1'b0, 0);
        // Issued while done is still high: back-to-back acceptance.
        run_conv("cordic_k", 32'h26DD3B6A, R_26DD, 5, 1'b0, 0);

        run_conv("stall", 32'h00010000, 32'h38800000, 23, 1'b0, 5);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check32("stall_done_held", {31'd0, done}, 32'd1);
        check32("stall_result_held", result, 32'h38800000);
        clk_en = 1'b1;
        @(posedge clk); #1;
        check32("done_clears", {31'd0, done}, 32'd0);
        check32("result_holds", result, 32'h38800000);

        start = 1'b1;
        dataa = 32'h00000001;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check32("abort_result", result, 32'h0);
        check32("abort_done", {31'd0, done}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check32("abort_no_done", seen, 0);

        run_conv("after_abort", 32'h40000000, 32'h3F800000, 4, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
